// File: rtl/debug_write_buffer.sv
// Debug write buffer: decodes CPU stores into the debug window, timestamps them,
// and queues them toward the debug sink with ready backpressure.
module debug_write_buffer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 8,
    parameter int          DROP_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_en_i,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_data_i,
    output logic              req_stall_o,
    output logic              dbg_en_o,
    output logic              dbg_we_o,
    output logic [23:0]       dbg_addr_o,
    output logic [31:0]       dbg_data_o,
    output logic [63:0]       dbg_tick_o,
    input  logic              dbg_ready_i,
    output logic [63:0]       tick_cntr_o,
    output logic              fifo_full_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [23:0] OFS_HALT    = 24'h000004;
    localparam logic [23:0] OFS_TRAFFIC = 24'h000008;

    logic [63:0]       r_tick;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [23:0]       r_mem_addr [DEPTH];
    logic [31:0]       r_mem_data [DEPTH];
    logic [63:0]       r_mem_tick [DEPTH];
    logic              r_dbg_en;
    logic [23:0]       r_dbg_addr;
    logic [31:0]       r_dbg_data;
    logic [63:0]       r_dbg_tick;
    logic              r_full;
    logic [DROP_W-1:0] r_drop;

    logic              w_hit;
    logic              w_lossless;
    logic              w_full_now;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic              w_drop;
    logic [AW:0]       w_wr_ptr_nxt;
    logic [AW:0]       w_rd_ptr_nxt;
    logic              w_bypass;
    logic              w_en_nxt;
    logic              w_full_nxt;
    logic [23:0]       w_head_addr;
    logic [31:0]       w_head_data;
    logic [63:0]       w_head_tick;

    assign w_hit      = req_en_i & req_we_i & (req_addr_i[31:24] == BASE_ADDR[31:24]);
    assign w_lossless = (req_addr_i[23:0] == OFS_HALT) | (req_addr_i[23:0] == OFS_TRAFFIC);
    assign w_full_now = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    assign w_pop      = r_dbg_en & dbg_ready_i;
    assign w_space    = ~w_full_now | w_pop;
    assign w_push     = w_hit & w_space;
    assign w_drop     = w_hit & ~w_lossless & ~w_space;

    assign req_stall_o = w_hit & w_lossless & ~w_space;

    assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_en_nxt     = (w_wr_ptr_nxt != w_rd_ptr_nxt);
    assign w_full_nxt   = (w_wr_ptr_nxt == {~w_rd_ptr_nxt[AW], w_rd_ptr_nxt[AW-1:0]});

    // The next head may be the slot being written this very cycle; forward it
    // so an entry into an empty FIFO is presented one cycle later.
    assign w_bypass = (w_rd_ptr_nxt == r_wr_ptr);

    always_comb begin
        w_head_addr = r_mem_addr[w_rd_ptr_nxt[AW-1:0]];
        w_head_data = r_mem_data[w_rd_ptr_nxt[AW-1:0]];
        w_head_tick = r_mem_tick[w_rd_ptr_nxt[AW-1:0]];
        if (w_bypass) begin
            w_head_addr = req_addr_i[23:0];
            w_head_data = req_data_i;
            w_head_tick = r_tick;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr[AW-1:0]] <= req_addr_i[23:0];
            r_mem_data[r_wr_ptr[AW-1:0]] <= req_data_i;
            r_mem_tick[r_wr_ptr[AW-1:0]] <= r_tick;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tick     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dbg_en   <= 1'b0;
            r_dbg_addr <= '0;
            r_dbg_data <= '0;
            r_dbg_tick <= '0;
            r_full     <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_tick     <= r_tick + 64'd1;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_dbg_en   <= w_en_nxt;
            r_dbg_addr <= w_head_addr;
            r_dbg_data <= w_head_data;
            r_dbg_tick <= w_head_tick;
            r_full     <= w_full_nxt;
            if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
                r_drop <= r_drop + {{(DROP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign tick_cntr_o = r_tick;
    assign dbg_en_o    = r_dbg_en;
    assign dbg_we_o    = r_dbg_en;
    assign dbg_addr_o  = r_dbg_addr;
    assign dbg_data_o  = r_dbg_data;
    assign dbg_tick_o  = r_dbg_tick;
    assign fifo_full_o = r_full;
    assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_debug_write_buffer.sv
// Bench for debug_write_buffer: decode table, directed corner sequences and a
// randomized run compared against a queue-based model of the buffer.
module tb_debug_write_buffer;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_en = 1'b0;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_data = '0;
    logic              req_stall;
    logic              dbg_en;
    logic              dbg_we;
    logic [23:0]       dbg_addr;
    logic [31:0]       dbg_data;
    logic [63:0]       dbg_tick;
    logic              dbg_ready = 1'b0;
    logic [63:0]       tick_cntr;
    logic              fifo_full;
    logic [DROP_W-1:0] drop_cnt;

    debug_write_buffer #(.BASE_ADDR(32'h8000_0000), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_en_i(req_en), .req_we_i(req_we), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_stall_o(req_stall),
        .dbg_en_o(dbg_en), .dbg_we_o(dbg_we), .dbg_addr_o(dbg_addr),
        .dbg_data_o(dbg_data), .dbg_tick_o(dbg_tick), .dbg_ready_i(dbg_ready),
        .tick_cntr_o(tick_cntr), .fifo_full_o(fifo_full), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] a;
        logic [31:0] d;
        logic [63:0] t;
    } ent_t;

    ent_t              m_q[$];
    logic [63:0]       m_tick = '0;
    logic [DROP_W-1:0] m_drop = '0;
    logic              m_last_stall = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic m_hit();
        return req_en && req_we && (req_addr[31:24] == 8'h80);
    endfunction

    function automatic logic m_lossless();
        return (req_addr[23:0] == 24'h4) || (req_addr[23:0] == 24'h8);
    endfunction

    function automatic logic m_space();
        return (m_q.size() < DEPTH) || dbg_ready;
    endfunction

    function automatic logic m_stall();
        return !rst && m_hit() && m_lossless() && !m_space();
    endfunction

    task automatic model_step();
        ent_t e;
        logic hit, space;
        if (rst) begin
            m_q.delete();
            m_tick = '0;
            m_drop = '0;
        end else begin
            hit   = m_hit();
            space = m_space();
            if (m_q.size() != 0 && dbg_ready) void'(m_q.pop_front());
            if (hit && space) begin
                e.a = req_addr[23:0];
                e.d = req_data;
                e.t = m_tick;
                m_q.push_back(e);
            end else if (hit && !m_lossless() && m_drop != '1) begin
                m_drop = m_drop + 1'b1;
            end
            m_tick = m_tick + 64'd1;
        end
    endtask

    task automatic check_model();
        m_last_stall = m_stall();
        chk("stall", {63'd0, req_stall}, {63'd0, m_last_stall});
        chk("dbg_en", {63'd0, dbg_en}, {63'd0, m_q.size() != 0});
        chk("dbg_we", {63'd0, dbg_we}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("dbg_addr", {40'd0, dbg_addr}, {40'd0, m_q[0].a});
            chk("dbg_data", {32'd0, dbg_data}, {32'd0, m_q[0].d});
            chk("dbg_tick", dbg_tick, m_q[0].t);
        end
        chk("tick_cntr", tick_cntr, m_tick);
        chk("fifo_full", {63'd0, fifo_full}, {63'd0, m_q.size() == DEPTH});
        chk("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_drop});
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then leave the caller 1 time unit after the edge to drive inputs.
    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input logic en, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_en = en; req_we = we; req_addr = a; req_data = d;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain(input int budget);
        dbg_ready = 1'b1;
        idle();
        for (int i = 0; i < budget && m_q.size() != 0; i++) cycle();
        chk("drain_done", {63'd0, m_q.size() == 0}, 64'd1);
        cycle();
    endtask

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_acc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [63:0]       t_saved;
        logic [DROP_W-1:0] d_saved;

        vecs[0] = '{1'b1, 1'b1, 32'h8000_0010, 32'h0000_1111, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h4000_0010, 32'h0000_2222, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0000_3333, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h8000_0010, 32'h0000_4444, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h80FF_FFFC, 32'hDEAD_BEEF, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h8100_0000, 32'h0000_5555, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_6666, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h8000_0004, 32'h0000_7777, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h8000_0008, 32'h0000_8888, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dbg_en", {63'd0, dbg_en}, 64'd0);
        chk("rst_tick", tick_cntr, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
        rst = 1'b0;

        // Single store at tick 5, presented the next cycle and gone after.
        dbg_ready = 1'b1;
        repeat (5) cycle();
        set_req(1'b1, 1'b1, 32'h8000_0000, 32'h41);
        cycle();
        idle();
        chk("single_en", {63'd0, dbg_en}, 64'd1);
        chk("single_addr", {40'd0, dbg_addr}, 64'd0);
        chk("single_data", {32'd0, dbg_data}, 64'h41);
        chk("single_tick", dbg_tick, 64'd5);
        cycle();
        chk("single_gone", {63'd0, dbg_en}, 64'd0);

        // Decode table, one access at a time into an empty buffer.
        for (int i = 0; i < 9; i++) begin
            set_req(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data);
            #1;
            chk($sformatf("vec%0d_stall", i), {63'd0, req_stall}, 64'd0);
            cycle();
            idle();
            chk($sformatf("vec%0d_en", i), {63'd0, dbg_en}, {63'd0, vecs[i].exp_acc});
            if (vecs[i].exp_acc) begin
                chk($sformatf("vec%0d_addr", i), {40'd0, dbg_addr}, {40'd0, vecs[i].addr[23:0]});
                chk($sformatf("vec%0d_data", i), {32'd0, dbg_data}, {32'd0, vecs[i].data});
            end
            cycle();
        end
        chk("filter_drop", {48'd0, drop_cnt}, 64'd0);

        // Lossy overflow: 10 writes while the sink is stalled.
        dbg_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_req(1'b1, 1'b1, 32'h8000_0010, 32'h100 + i);
            cycle();
        end
        idle();
        chk("ovf_full", {63'd0, fifo_full}, 64'd1);
        chk("ovf_drop", {48'd0, drop_cnt}, 64'd2);

        // Lossless store against a full buffer stalls until the sink pops.
        set_req(1'b1, 1'b1, 32'h8000_0004, 32'h0000_0ABC);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_stall", {63'd0, req_stall}, 64'd1);
            cycle();
        end
        dbg_ready = 1'b1;
        #1;
        chk("halt_accept", {63'd0, req_stall}, 64'd0);
        t_saved = m_tick;
        cycle();
        idle();
        chk("halt_still_full", {63'd0, fifo_full}, 64'd1);
        chk("halt_no_drop", {48'd0, drop_cnt}, 64'd2);
        for (int i = 0; i < 20 && m_q.size() > 1; i++) cycle();
        chk("halt_last_en", {63'd0, dbg_en}, 64'd1);
        chk("halt_last_addr", {40'd0, dbg_addr}, 64'h4);
        chk("halt_last_tick", dbg_tick, t_saved);
        drain(20);

        // Simultaneous push and pop while full.
        dbg_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1, 1'b1, 32'h8000_0020, 32'h200 + i);
            cycle();
        end
        d_saved = m_drop;
        dbg_ready = 1'b1;
        set_req(1'b1, 1'b1, 32'h8000_0030, 32'h0000_0300);
        cycle();
        idle();
        dbg_ready = 1'b0;
        chk("pp_full", {63'd0, fifo_full}, 64'd1);
        chk("pp_drop", {48'd0, drop_cnt}, {48'd0, d_saved});
        chk("pp_head", {32'd0, dbg_data}, 64'h201);
        drain(20);

        // Reset in the middle of a queued stream.
        dbg_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b1, 32'h8000_0040, 32'h400 + i);
            cycle();
        end
        idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_en", {63'd0, dbg_en}, 64'd0);
        chk("mid_rst_drop", {48'd0, drop_cnt}, 64'd0);
        chk("mid_rst_full", {63'd0, fifo_full}, 64'd0);
        m_q.delete();
        m_tick = '0;
        m_drop = '0;
        cycle();
        rst = 1'b0;
        dbg_ready = 1'b1;
        cycle();
        chk("post_rst_tick", tick_cntr, 64'd1);
        chk("post_rst_en", {63'd0, dbg_en}, 64'd0);
        cycle();

        // Randomized traffic against the model; stalled accesses are held.
        for (int i = 0; i < 600; i++) begin
            if (!m_last_stall) begin
                logic [31:0] a;
                case ($urandom_range(0, 4))
                    0:       a = 32'h0000_0004;
                    1:       a = 32'h0000_0008;
                    2:       a = 32'h0000_0010;
                    default: a = {8'h00, 24'($urandom)};
                endcase
                a[31:24] = ($urandom_range(0, 3) != 0) ? 8'h80 : 8'($urandom);
                set_req($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, a, $urandom);
            end
            dbg_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debug_write_buffer.md
Name: debug_write_buffer

Overview:
- Sits between the PE's CPU data bus and the simulation debug sink; it is the sink's direct upstream stage.
- Decodes stores that fall in the debug address window and timestamps each one with an internal tick counter.
- Buffers accepted stores in a FIFO and presents them one at a time on the sink's en/we/addr/data/tick interface, with ready backpressure.
- Loss policy: halt and traffic stores are never dropped; they stall the CPU instead. Other stores are dropped on overflow and counted.

Parameters:
- BASE_ADDR, 32'h8000_0000, debug window base; a store matches when addr[31:24] == BASE_ADDR[31:24].
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DROP_W, 16, width of the dropped-store counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_en_i  in  1  CPU bus access valid
- req_we_i  in  1  CPU access is a write
- req_addr_i  in  32  CPU byte address
- req_data_i  in  32  CPU write data
- req_stall_o  out  1  CPU must hold the current access (combinational)
- dbg_en_o  out  1  entry valid toward the sink
- dbg_we_o  out  1  always equals dbg_en_o
- dbg_addr_o  out  24  window offset of the entry
- dbg_data_o  out  32  write data of the entry
- dbg_tick_o  out  64  tick value captured at acceptance
- dbg_ready_i  in  1  sink consumes the head entry this cycle
- tick_cntr_o  out  64  free-running tick counter
- fifo_full_o  out  1  occupancy == DEPTH
- drop_cnt_o  out  DROP_W  dropped-store count, saturating

Behaviour:
- Reset (async assert, sync release): tick_cntr_o=0, FIFO empty, dbg_en_o=0, dbg_we_o=0, dbg_addr_o=0, dbg_data_o=0, dbg_tick_o=0, drop_cnt_o=0, fifo_full_o=0.
- Reset asserted mid-operation discards all buffered entries immediately; no partial entry is emitted after release.
- Tick counter:
  - Increments by 1 every cycle out of reset; wraps modulo 2^64.
  - First cycle after release shows 0, next cycle 1.
- Hit: req_en_i & req_we_i & (req_addr_i[31:24] == BASE_ADDR[31:24]). Reads and non-window writes are ignored entirely.
- Lossless offsets: 24'h000004 (halt) and 24'h000008 (traffic). All other offsets are lossy.
- Pop: dbg_en_o & dbg_ready_i.
- Space exists in a cycle when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs that cycle (simultaneous push/pop while full is accepted; occupancy unchanged).
- A hit with space is accepted. The stored entry is {req_addr_i[23:0], req_data_i, tick_cntr_o of that same cycle}.
- A lossless hit without space sets req_stall_o=1 combinationally that cycle. Nothing is stored. The CPU re-presents the access, and it is accepted in the first cycle with space.
- A lossy hit without space is discarded; drop_cnt_o increments and saturates at all-ones. req_stall_o stays 0.
- req_stall_o is never asserted for misses, reads or lossy hits.
- Output side:
  - dbg_* are registered from the FIFO head.
  - An entry accepted at cycle N into an empty FIFO has dbg_en_o=1 at cycle N+1; minimum latency is 1 cycle.
  - dbg_* hold stable while dbg_en_o=1 and dbg_ready_i=0.
  - After a pop the next entry is presented the following cycle, so one entry per cycle sustained.
  - When the FIFO is empty, dbg_en_o=0 and the other dbg_* fields are don't-care.
- Ordering: strict FIFO; entries leave in acceptance order.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full: pointers differ only in the MSB. Empty: pointers are equal.
- fifo_full_o is registered and reflects the occupancy after the current cycle's push/pop.

Test Plan:
- Single store: after reset, with dbg_ready_i=1, write 0x8000_0000 / data 0x41 at tick 5 -> cycle 6 shows dbg_en_o=1, addr 0x000000, data 0x41, tick 5; dbg_en_o=0 at cycle 7.
- Filtering: write 0x4000_0010, then read 0x8000_0010 -> no entry produced, drop_cnt_o=0, req_stall_o=0.
- Overflow, lossy: dbg_ready_i=0, 10 writes to offset 0x10 on consecutive cycles, DEPTH=8 -> fifo_full_o=1 and drop_cnt_o=2; releasing ready drains 8 entries in order with ticks strictly increasing.
- Overflow, lossless: FIFO full, dbg_ready_i=0, write offset 0x04 -> req_stall_o=1 for 3 cycles; raise ready at cycle 3 -> store accepted that cycle and emitted last with the cycle-3 tick.
- Simultaneous push/pop while full: dbg_ready_i=1 and a new write in the same cycle -> accepted, occupancy stays 8, no drop.
- Reset mid-stream: 5 entries queued, rst_i pulsed -> dbg_en_o=0 and drop_cnt_o=0 immediately; after release tick_cntr_o restarts at 0 and no stale entry appears.
